// File: rtl/exu_muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit:
// operation-info bit positions and FSM state encoding.
package exu_muldiv_pkg;

    localparam int MD_MUL    = 8;
    localparam int MD_MULH   = 7;
    localparam int MD_MULHSU = 6;
    localparam int MD_MULHU  = 5;
    localparam int MD_DIV    = 4;
    localparam int MD_DIVU   = 3;
    localparam int MD_REM    = 2;
    localparam int MD_REMU   = 1;
    localparam int MD_WORD   = 0;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/exu_muldiv_iter_core.sv
// Shared unsigned shift/add-subtract datapath: MSB-first shift-add multiply
// or restoring divide on magnitudes, STEP bits per cycle.
module exu_muldiv_iter_core #(
    parameter int XLEN = 64,
    parameter int STEP = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_load,
    input  logic            i_run,
    input  logic            i_div,
    input  logic [6:0]      i_n,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_last,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN-1:0] sh_q, sh_d, hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [6:0]      cnt_q, cnt_d;
    logic            div_q, div_d;

    logic [XLEN-1:0]   h, l, s;
    logic [XLEN:0]     r;
    logic [2*XLEN-1:0] acc;
    logic [6:0]        shamt;

    // The operand is pre-shifted so its top significant bit sits at the MSB;
    // both modes then consume bits MSB-first regardless of N.
    always_comb begin
        sh_d  = sh_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        div_d = div_q;
        h     = hi_q;
        l     = lo_q;
        s     = sh_q;
        r     = '0;
        acc   = '0;
        shamt = 7'(XLEN) - i_n;
        if (i_load) begin
            sh_d  = i_a << shamt;
            hi_d  = '0;
            lo_d  = '0;
            b_d   = i_b;
            div_d = i_div;
            cnt_d = i_n / 7'(STEP);
        end else if (i_run) begin
            for (int k = 0; k < STEP; k++) begin
                if (div_q) begin
                    r = {h, s[XLEN-1]};
                    if (r >= {1'b0, b_q}) begin
                        r = r - {1'b0, b_q};
                        l = {l[XLEN-2:0], 1'b1};
                    end else begin
                        l = {l[XLEN-2:0], 1'b0};
                    end
                    h = r[XLEN-1:0];
                end else begin
                    acc = {h, l} << 1;
                    if (s[XLEN-1]) begin
                        acc = acc + {{XLEN{1'b0}}, b_q};
                    end
                    {h, l} = acc;
                end
                s = s << 1;
            end
            sh_d  = s;
            hi_d  = h;
            lo_d  = l;
            cnt_d = cnt_q - 7'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_q  <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else begin
            sh_q  <= sh_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            div_q <= div_d;
        end
    end

    // Next-state halves, so the owner can capture the result on the last step.
    assign o_hi   = hi_d;
    assign o_lo   = lo_d;
    assign o_last = (cnt_q == 7'd1);

endmodule

// File: rtl/exu_muldiv.sv
// RV64M iterative multiply/divide execute unit: handshake FSM, sign handling,
// divide special cases and word-op formatting around the shared iterative core.
module exu_muldiv
    import exu_muldiv_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int STEP = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [8:0]      i_md_info,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_op2,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_rd_wen,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_rd_data,
    output logic [4:0]      o_rd_addr,
    output logic            o_rd_wen,
    output logic [1:0]      o_dbg_state
);

    // Handshake: a request transfers when i_valid & o_ready & ~i_flush; the result
    // transfers when o_valid & i_ready; o_valid holds with stable data until then.

    function automatic logic [XLEN-1:0] fmt(input logic w, input logic [XLEN-1:0] x);
        return w ? XLEN'($signed(x[31:0])) : x;
    endfunction

    state_t          state_q, state_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic            rd_wen_q, rd_wen_d, word_q, word_d, mul_q, mul_d;
    logic            lo_sel_q, lo_sel_d, neg_q, neg_d;

    logic              op_mul, op_div, word, a_signed, b_signed, lo_sel;
    logic              a_neg, b_neg, div0, ovf, special, accept;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_val, special_res;
    logic              core_load, core_run, core_last;
    logic [XLEN-1:0]   core_hi, core_lo, quo, remv, raw, calc_res;
    logic [2*XLEN-1:0] full, prod;
    logic [6:0]        n_iter;

    assign op_mul   = |i_md_info[MD_MUL:MD_MULHU];
    assign op_div   = |i_md_info[MD_DIV:MD_REMU];
    assign word     = i_md_info[MD_WORD] & (i_md_info[MD_MUL] | op_div) & (XLEN == 64);
    assign a_signed = i_md_info[MD_MULH] | i_md_info[MD_MULHSU] | i_md_info[MD_DIV] | i_md_info[MD_REM];
    assign b_signed = i_md_info[MD_MULH] | i_md_info[MD_DIV] | i_md_info[MD_REM];
    assign lo_sel   = i_md_info[MD_MUL] | i_md_info[MD_DIV] | i_md_info[MD_DIVU];

    assign a_ext = word ? (a_signed ? XLEN'($signed(i_op1[31:0])) : XLEN'(i_op1[31:0])) : i_op1;
    assign b_ext = word ? (b_signed ? XLEN'($signed(i_op2[31:0])) : XLEN'(i_op2[31:0])) : i_op2;
    assign a_neg = a_signed & a_ext[XLEN-1];
    assign b_neg = b_signed & b_ext[XLEN-1];
    assign a_mag = a_neg ? -a_ext : a_ext;
    assign b_mag = b_neg ? -b_ext : b_ext;
    assign n_iter = word ? 7'd32 : 7'(XLEN);

    assign min_val = word ? XLEN'($signed(32'h8000_0000)) : {1'b1, {(XLEN-1){1'b0}}};
    assign div0    = op_div & (b_ext == '0);
    assign ovf     = (i_md_info[MD_DIV] | i_md_info[MD_REM]) & (a_ext == min_val) & (&b_ext);
    assign special = div0 | ovf;
    assign special_res = div0 ? (lo_sel ? '1 : fmt(word, a_ext)) : (lo_sel ? a_ext : '0);

    assign accept = i_valid & (state_q == ST_IDLE) & ~i_flush;

    exu_muldiv_iter_core #(.XLEN(XLEN), .STEP(STEP)) u_core (
        .clock  (clock),
        .reset  (reset),
        .i_load (core_load),
        .i_run  (core_run),
        .i_div  (op_div),
        .i_n    (n_iter),
        .i_a    (a_mag),
        .i_b    (b_mag),
        .o_last (core_last),
        .o_hi   (core_hi),
        .o_lo   (core_lo)
    );

    // Products negate as a full 2*XLEN value so the high half borrows correctly.
    assign full     = {core_hi, core_lo};
    assign prod     = neg_q ? -full : full;
    assign quo      = neg_q ? -core_lo : core_lo;
    assign remv     = neg_q ? -core_hi : core_hi;
    assign raw      = mul_q ? (lo_sel_q ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                            : (lo_sel_q ? quo : remv);
    assign calc_res = fmt(word_q, raw);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
            ST_CALC: begin
                if (i_flush)        state_d = ST_IDLE;
                else if (core_last) state_d = ST_DONE;
            end
            ST_DONE: if (i_flush || i_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_ready     = (state_q == ST_IDLE);
        o_valid     = (state_q == ST_DONE);
        o_dbg_state = state_q;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        rd_addr_d = rd_addr_q;
        rd_wen_d  = rd_wen_q;
        word_d    = word_q;
        mul_d     = mul_q;
        lo_sel_d  = lo_sel_q;
        neg_d     = neg_q;
        core_load = 1'b0;
        core_run  = (state_q == ST_CALC);
        if (accept) begin
            rd_addr_d = i_rd_addr;
            rd_wen_d  = i_rd_wen;
            word_d    = word;
            mul_d     = op_mul;
            lo_sel_d  = lo_sel;
            neg_d     = (op_mul | lo_sel) ? (a_neg ^ b_neg) : a_neg;
            if (special) rd_data_d = special_res;
            else         core_load = 1'b1;
        end
        if ((state_q == ST_CALC) && core_last && !i_flush) begin
            rd_data_d = calc_res;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
            rd_addr_q <= '0;
            rd_wen_q  <= 1'b0;
            word_q    <= 1'b0;
            mul_q     <= 1'b0;
            lo_sel_q  <= 1'b0;
            neg_q     <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_addr_q <= rd_addr_d;
            rd_wen_q  <= rd_wen_d;
            word_q    <= word_d;
            mul_q     <= mul_d;
            lo_sel_q  <= lo_sel_d;
            neg_q     <= neg_d;
        end
    end

    assign o_rd_data = rd_data_q;
    assign o_rd_addr = rd_addr_q;
    assign o_rd_wen  = rd_wen_q;

endmodule

// File: tb/tb_exu_muldiv.sv
// Bench for exu_muldiv: directed and random operations on a STEP=1 and a STEP=4
// instance, scored against an arithmetic reference model with latency checks.
module tb_exu_muldiv;

    localparam logic [8:0] I_MUL    = 9'h100;
    localparam logic [8:0] I_MULH   = 9'h080;
    localparam logic [8:0] I_MULHSU = 9'h040;
    localparam logic [8:0] I_MULHU  = 9'h020;
    localparam logic [8:0] I_DIV    = 9'h010;
    localparam logic [8:0] I_DIVU   = 9'h008;
    localparam logic [8:0] I_REM    = 9'h004;
    localparam logic [8:0] I_REMU   = 9'h002;
    localparam logic [8:0] I_W      = 9'h001;
    localparam logic [31:0] W_MIN   = 32'h8000_0000;
    localparam logic [63:0] L_MIN   = 64'h8000_0000_0000_0000;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [8:0]  md = '0;
    logic [63:0] op1 = '0, op2 = '0;
    logic [4:0]  rd = '0;
    logic        wen = 1'b0, flush = 1'b0;
    logic        v1 = 1'b0, r1 = 1'b0, v4 = 1'b0, r4 = 1'b0;

    logic        rdy1, ov1, wen1, rdy4, ov4, wen4;
    logic [63:0] data1, data4;
    logic [4:0]  addr1, addr4;
    logic [1:0]  st1, st4;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    exu_muldiv #(.XLEN(64), .STEP(1)) dut1 (
        .clock(clock), .reset(reset), .i_valid(v1), .o_ready(rdy1), .i_md_info(md),
        .i_op1(op1), .i_op2(op2), .i_rd_addr(rd), .i_rd_wen(wen), .i_flush(flush),
        .o_valid(ov1), .i_ready(r1), .o_rd_data(data1), .o_rd_addr(addr1),
        .o_rd_wen(wen1), .o_dbg_state(st1)
    );

    exu_muldiv #(.XLEN(64), .STEP(4)) dut4 (
        .clock(clock), .reset(reset), .i_valid(v4), .o_ready(rdy4), .i_md_info(md),
        .i_op1(op1), .i_op2(op2), .i_rd_addr(rd), .i_rd_wen(wen), .i_flush(flush),
        .o_valid(ov4), .i_ready(r4), .o_rd_data(data4), .o_rd_addr(addr4),
        .o_rd_wen(wen4), .o_dbg_state(st4)
    );

    // ---------------- reference model ----------------
    function automatic bit is_word(input logic [8:0] info);
        return info[0] && (info[8] || (info[4:1] != 4'b0));
    endfunction

    function automatic logic [63:0] ref_result(input logic [8:0] info, input logic [63:0] a,
                                               input logic [63:0] b);
        logic [127:0] p;
        logic [31:0]  r32;
        logic [63:0]  r;
        int           sa32, sb32;
        longint       sa, sb;
        bit           ovf32, ovf64;
        sa32 = $signed(a[31:0]);
        sb32 = $signed(b[31:0]);
        sa = $signed(a);
        sb = $signed(b);
        ovf32 = (a[31:0] == W_MIN) && (b[31:0] == 32'hFFFF_FFFF);
        ovf64 = (a == L_MIN) && (b == 64'hFFFF_FFFF_FFFF_FFFF);
        r32 = '0;
        r = '0;
        p = '0;
        if (is_word(info)) begin
            if (info[8]) r32 = a[31:0] * b[31:0];
            else if (info[4]) begin
                if (sb32 == 0) r32 = '1;
                else if (ovf32) r32 = a[31:0];
                else r32 = sa32 / sb32;
            end else if (info[3]) begin
                if (b[31:0] == 0) r32 = '1;
                else r32 = a[31:0] / b[31:0];
            end else if (info[2]) begin
                if (sb32 == 0) r32 = a[31:0];
                else if (ovf32) r32 = '0;
                else r32 = sa32 % sb32;
            end else begin
                if (b[31:0] == 0) r32 = a[31:0];
                else r32 = a[31:0] % b[31:0];
            end
            r = {{32{r32[31]}}, r32};
        end else begin
            if (info[8]) r = a * b;
            else if (info[7]) begin
                p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
                r = p[127:64];
            end else if (info[6]) begin
                p = $signed({{64{a[63]}}, a}) * $signed({64'b0, b});
                r = p[127:64];
            end else if (info[5]) begin
                p = {64'b0, a} * {64'b0, b};
                r = p[127:64];
            end else if (info[4]) begin
                if (sb == 0) r = '1;
                else if (ovf64) r = a;
                else r = sa / sb;
            end else if (info[3]) begin
                if (b == 0) r = '1;
                else r = a / b;
            end else if (info[2]) begin
                if (sb == 0) r = a;
                else if (ovf64) r = '0;
                else r = sa % sb;
            end else begin
                if (b == 0) r = a;
                else r = a % b;
            end
        end
        return r;
    endfunction

    function automatic int exp_latency(input logic [8:0] info, input logic [63:0] a,
                                       input logic [63:0] b, input int step);
        bit w, zero, ovf;
        w = is_word(info);
        if (info[4:1] != 4'b0) begin
            zero = w ? (b[31:0] == 0) : (b == 0);
            ovf  = (info[4] || info[2]) &&
                   (w ? (a[31:0] == W_MIN && b[31:0] == 32'hFFFF_FFFF)
                      : (a == L_MIN && b == 64'hFFFF_FFFF_FFFF_FFFF));
            if (zero || ovf) return 1;
        end
        return (w ? 32 : 64) / step + 1;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 4) ? rdy4 : rdy1;
    endfunction
    function automatic logic get_valid(input int sel);
        return (sel == 4) ? ov4 : ov1;
    endfunction
    function automatic logic [63:0] get_data(input int sel);
        return (sel == 4) ? data4 : data1;
    endfunction
    function automatic logic [4:0] get_addr(input int sel);
        return (sel == 4) ? addr4 : addr1;
    endfunction
    function automatic logic get_wen(input int sel);
        return (sel == 4) ? wen4 : wen1;
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_valid(input int sel, input logic v);
        if (sel == 4) v4 = v;
        else v1 = v;
    endtask

    task automatic drive_ready(input int sel, input logic r);
        if (sel == 4) r4 = r;
        else r1 = r;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ":ready"}, {63'b0, rdy1}, 64'd1);
        chk({tag, ":valid"}, {63'b0, ov1}, 64'd0);
        chk({tag, ":data"}, data1, 64'd0);
        chk({tag, ":addr"}, {59'b0, addr1}, 64'd0);
        chk({tag, ":wen"}, {63'b0, wen1}, 64'd0);
    endtask

    task automatic do_op(input int sel, input logic [8:0] info, input logic [63:0] a,
                         input logic [63:0] b, input int hold, input string tag);
        logic [63:0] exp_d;
        logic [4:0]  rd_v;
        logic        wen_v;
        int          lat, lat_exp;
        lat_exp = exp_latency(info, a, b, (sel == 4) ? 4 : 1);
        rd_v  = 5'($urandom_range(0, 31));
        wen_v = 1'($urandom_range(0, 1));
        @(negedge clock);
        chk({tag, ":o_ready_idle"}, {63'b0, get_ready(sel)}, 64'd1);
        md = info;
        op1 = a;
        op2 = b;
        rd = rd_v;
        wen = wen_v;
        drive_valid(sel, 1'b1);
        exp_q.push_back(ref_result(info, a, b));
        @(negedge clock);
        drive_valid(sel, 1'b0);
        op1 = {$urandom, $urandom};
        op2 = {$urandom, $urandom};
        md = 9'($urandom);
        rd = 5'($urandom);
        lat = 1;
        while (get_valid(sel) !== 1'b1 && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        exp_d = exp_q.pop_front();
        chk({tag, ":latency"}, 64'(lat), 64'(lat_exp));
        chk({tag, ":data"}, get_data(sel), exp_d);
        chk({tag, ":rd_addr"}, {59'b0, get_addr(sel)}, {59'b0, rd_v});
        chk({tag, ":rd_wen"}, {63'b0, get_wen(sel)}, {63'b0, wen_v});
        for (int k = 0; k < hold; k++) begin
            @(negedge clock);
            chk({tag, ":hold_valid"}, {63'b0, get_valid(sel)}, 64'd1);
            chk({tag, ":hold_data"}, get_data(sel), exp_d);
            chk({tag, ":hold_ready"}, {63'b0, get_ready(sel)}, 64'd0);
        end
        drive_ready(sel, 1'b1);
        @(negedge clock);
        drive_ready(sel, 1'b0);
        chk({tag, ":post_valid"}, {63'b0, get_valid(sel)}, 64'd0);
        chk({tag, ":post_ready"}, {63'b0, get_ready(sel)}, 64'd1);
    endtask

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 6))
            0: return {$urandom, $urandom};
            1: return 64'($urandom_range(0, 20));
            2: return -64'($urandom_range(1, 20));
            3: return 64'd0;
            4: return ($urandom_range(0, 1) == 1) ? L_MIN : 64'hFFFF_FFFF_8000_0000;
            5: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int seen;
        logic [8:0] info;
        #1 reset = 1'b1;
        #1 check_reset_values("reset_init");
        @(negedge clock);
        reset = 1'b0;

        do_op(1, I_MUL, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 0, "mul_7_m3");
        do_op(1, I_MULHU, '1, '1, 0, "mulhu_max");
        do_op(1, I_MULHSU, '1, 64'd2, 0, "mulhsu_m1_2");
        do_op(1, I_DIV, -64'd7, 64'd2, 0, "div_m7_2");
        do_op(1, I_REM, -64'd7, 64'd2, 0, "rem_m7_2");
        do_op(1, I_DIVU | I_W, 64'h1_0000_0010, 64'd4, 0, "divuw");
        do_op(1, I_DIV, 64'h1234_5678_9ABC_DEF0, 64'd0, 0, "div_by0");
        do_op(1, I_REMU, 64'd5, 64'd0, 0, "remu_by0");
        do_op(1, I_DIV, L_MIN, '1, 0, "div_ovf");
        do_op(1, I_REM, L_MIN, '1, 0, "rem_ovf");
        do_op(1, I_REMW_SAFE(), 64'hFFFF_FFFF_0000_0009, 64'd0, 0, "remuw_by0");
        do_op(1, I_MUL | I_W, 64'h0000_0001_8000_0001, 64'd3, 0, "mulw");
        do_op(1, I_DIV, 64'd100, 64'd7, 5, "backpressure");
        do_op(4, I_DIV, -64'd7, 64'd2, 0, "step4_div");

        // Flush on the 10th CALC cycle: unit goes idle and never presents a result.
        @(negedge clock);
        md = I_MUL; op1 = 64'd9; op2 = 64'd9; v1 = 1'b1;
        @(negedge clock);
        v1 = 1'b0;
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("flush:ready", {63'b0, rdy1}, 64'd1);
        chk("flush:valid", {63'b0, ov1}, 64'd0);
        seen = 0;
        repeat (80) begin
            @(negedge clock);
            if (ov1 === 1'b1) seen++;
        end
        chk("flush:no_result", 64'(seen), 64'd0);

        // A request presented together with flush is not taken.
        md = I_DIVU; op1 = 64'd50; op2 = 64'd5; v1 = 1'b1; flush = 1'b1;
        @(negedge clock);
        v1 = 1'b0; flush = 1'b0;
        chk("flush_req:ready", {63'b0, rdy1}, 64'd1);
        seen = 0;
        repeat (70) begin
            @(negedge clock);
            if (ov1 === 1'b1) seen++;
        end
        chk("flush_req:no_result", 64'(seen), 64'd0);

        // Async reset in the middle of a calculation.
        md = I_DIV; op1 = 64'd1000; op2 = 64'd3; rd = 5'd17; wen = 1'b1; v1 = 1'b1;
        @(negedge clock);
        v1 = 1'b0;
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1 check_reset_values("reset_mid");
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 40; i++) begin
            info = 9'h100 >> $urandom_range(0, 7);
            if ($urandom_range(0, 2) == 0) info = info | I_W;
            do_op(((i % 4) == 3) ? 4 : 1, info, rnd_operand(), rnd_operand(),
                  ($urandom_range(0, 3) == 0) ? 2 : 0, $sformatf("rand%0d_%h", i, info));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [8:0] I_REMW_SAFE();
        return I_REMU | I_W;
    endfunction

endmodule

// File: doc/exu_muldiv.md
Name: exu_muldiv

Overview:
- Iterative RV64M multiply/divide execute unit, parametrised in XLEN and bits retired per cycle.
- Sits beside the single-cycle ALU in EX. The pipeline control stalls EX while this unit is busy.
- Uses a valid/ready handshake on both input and output, plus a flush input to kill an in-flight op.
- Carries the rd address and rd write-enable through to its result.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64. Word ops are only legal when XLEN=64.
- STEP, 1, quotient/multiplier bits retired per cycle; legal values 1, 2, 4. Must divide 32.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- i_valid  in  1  operation request
- o_ready  out  1  unit idle and able to accept a request
- i_md_info  in  9  [8]mul [7]mulh [6]mulhsu [5]mulhu [4]div [3]divu [2]rem [1]remu (one-hot), [0]word
- i_op1  in  XLEN  rs1 value, already forwarded
- i_op2  in  XLEN  rs2 value, already forwarded
- i_rd_addr  in  5  destination register
- i_rd_wen  in  1  destination write enable
- i_flush  in  1  kill any in-flight operation
- o_valid  out  1  result available
- i_ready  in  1  downstream accepts the result
- o_rd_data  out  XLEN  result
- o_rd_addr  out  5  captured rd address
- o_rd_wen  out  1  captured rd write enable

Behaviour:
- Reset values: state=IDLE, o_valid=0, o_ready=1, o_rd_data=0, o_rd_addr=0, o_rd_wen=0.
- States: IDLE -> CALC -> DONE -> IDLE. o_ready = (state==IDLE).
- Accept: i_valid & o_ready & ~i_flush. On accept, capture operands, op, rd_addr and rd_wen.
- Word flag on mul/div/divu/rem/remu (XLEN=64):
  - Operands are the low 32 bits, sign-extended for signed ops and zero-extended for unsigned ops.
  - N=32 iterations.
  - Result is the low 32 bits sign-extended to XLEN.
- Otherwise N=XLEN iterations. The word flag is ignored for the mulh* ops.
- Signed ops: convert operands to magnitudes at accept. Negate the final result when capturing it in DONE:
  - product negated when the operand signs differ;
  - quotient negated when the signs differ;
  - remainder takes the sign of the dividend.
- Multiplier: shift-add with a 2N-bit accumulator, STEP bits per cycle.
  - mul returns the low half; mulh/mulhsu/mulhu return the high half.
- Divider: restoring division, STEP quotient bits per cycle.
- Latency: accept in cycle T; CALC occupies N/STEP cycles; o_valid rises in cycle T+N/STEP+1.
- Divisor==0, resolved in IDLE with no CALC; o_valid in cycle T+1:
  - quotient = all ones;
  - remainder = dividend (word width where applicable, then sign-extended).
- Signed overflow (dividend = most-negative value, divisor = -1), also resolved in IDLE:
  - quotient = dividend;
  - remainder = 0.
- DONE:
  - o_valid is held and o_rd_data stays stable until i_ready.
  - On o_valid & i_ready, go to IDLE next cycle.
  - A new request is not accepted in the same cycle as the result handoff; o_ready is still 0.
- Flush: in any state, i_flush sends the unit to IDLE next cycle with o_valid=0. The result is discarded. A request presented with i_flush is not accepted.
- Reset mid-operation: immediate return to the reset values.
- o_rd_data retains its last value in IDLE. Consumers qualify it with o_valid.

Decomposition:
- Shared defines file:
  - MD_INFO bit-index constants (MD_MUL .. MD_REMU, MD_WORD);
  - state encoding localparams.
- One natural sub-module: muldiv_iter_core, the shared shift/add-subtract datapath. It takes the mode (mul/div), magnitudes and iteration count, and returns the raw hi/lo halves.
- exu_muldiv keeps the FSM, sign handling, special cases and the handshake.

Test Plan:
- XLEN=64, STEP=1, mul 0x7 x 0xFFFF_FFFF_FFFF_FFFD -> o_rd_data=0xFFFF_FFFF_FFFF_FFEB (-21), o_valid at T+65.
- mulhu 0xFFFF_FFFF_FFFF_FFFF x 0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. mulhsu -1 x 2 -> 0xFFFF_FFFF_FFFF_FFFF.
- div -7 / 2 -> 0xFFFF_FFFF_FFFF_FFFD; rem -7 % 2 -> 0xFFFF_FFFF_FFFF_FFFF. divuw 0x1_0000_0010 / 4 -> 0x4, o_valid at T+33.
- div x / 0 -> all ones at T+1; remu 5 % 0 -> 5. div 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; rem -> 0.
- Back-pressure: hold i_ready=0 for 5 cycles in DONE -> o_valid and data stable and o_ready=0; release -> o_ready=1 one cycle later.
- i_flush in the 10th CALC cycle -> next cycle IDLE, o_valid never asserted. Async reset mid-CALC -> all outputs at reset values immediately. STEP=4 run of the div case -> same result at T+17.
